ddr_app_model: RTL and testbench

- Synthesizable, parametrised successor to the simulation-only DDR app-interface model used by accelerator benches.
- Presents a MIG-style native app interface (command, write-data and read-return channels) on one clock, backed by on-chip word memory.
- Adds over the previous generation:
  - unified in-order command FIFO preserving read-after-write ordering;
  - per-byte write mask;
  - configurable latency and LFSR-driven backpressure;
  - illegal-command flag.
- Usable in RTL sim and on FPGA for bring-up without a real memory controller.

---
 rtl/ddr_app_model.sv | 170 +++++++++++++++++
 tb/tb_ddr_app_model.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_app_model.sv
// MIG-style native app interface backed by on-chip word memory: in-order command FIFO,
// write-data FIFO with byte mask, programmable minimum latency and LFSR-driven backpressure.
module ddr_app_model #(
    parameter int          APP_DATA_WIDTH = 512,
    parameter int          APP_ADDR_WIDTH = 30,
    parameter int          ADDR_SHIFT     = 3,
    parameter int          MEM_AW         = 10,
    parameter int          CMD_DEPTH_LOG2 = 4,
    parameter int          WDF_DEPTH_LOG2 = 4,
    parameter int          MIN_LATENCY    = 12,
    parameter int          INIT_CYCLES    = 64,
    parameter int          STALL_THRESH   = 77,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        init_done,
    output logic                        app_rdy,
    input  logic                        app_en,
    input  logic [2:0]                  app_cmd,
    input  logic [APP_ADDR_WIDTH-1:0]   app_addr,
    output logic                        app_wdf_rdy,
    input  logic                        app_wdf_wren,
    input  logic                        app_wdf_end,
    input  logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [APP_DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic [APP_DATA_WIDTH-1:0]   app_rd_data,
    output logic                        app_rd_data_valid,
    output logic                        app_rd_data_end,
    output logic                        err_cmd,
    output logic [1:0]                  dbg_state
);

    localparam int MASK_W    = APP_DATA_WIDTH / 8;
    localparam int CMD_DEPTH = 1 << CMD_DEPTH_LOG2;
    localparam int WDF_DEPTH = 1 << WDF_DEPTH_LOG2;
    localparam int MEM_DEPTH = 1 << MEM_AW;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Handshakes: a command beat transfers on a rising edge with app_en & app_rdy, a data beat
    // with app_wdf_wren & app_wdf_rdy; both readies are registered and independent of the
    // inputs. Read return has no ready: app_rd_data_valid pulses for one cycle per read.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_AGE = 2'd1,
        S_EXEC     = 2'd2
    } state_t;

    state_t state, state_d;

    logic [15:0] init_cnt;
    logic [7:0]  cyc_cnt;
    logic [15:0] lfsr, lfsr_d;
    logic        init_done_d, app_rdy_d, app_wdf_rdy_d;

    logic [CMD_DEPTH_LOG2-1:0] cmd_wr_ptr, cmd_rd_ptr;
    logic [CMD_DEPTH_LOG2:0]   cmd_count, cmd_count_d;
    logic [WDF_DEPTH_LOG2-1:0] wdf_wr_ptr, wdf_rd_ptr;
    logic [WDF_DEPTH_LOG2:0]   wdf_count, wdf_count_d;

    logic cmd_push, cmd_illegal, cmd_pop, wdf_push, wdf_pop;
    logic              head_is_rd;
    logic [MEM_AW-1:0] head_idx;
    logic [7:0]        head_age_next;

    logic                      cmd_rd_q  [CMD_DEPTH];
    logic [MEM_AW-1:0]         cmd_idx_q [CMD_DEPTH];
    logic [7:0]                cmd_ts_q  [CMD_DEPTH];
    logic [APP_DATA_WIDTH-1:0] wdf_data_q [WDF_DEPTH];
    logic [MASK_W-1:0]         wdf_mask_q [WDF_DEPTH];
    logic [APP_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic unused_inputs;
    assign unused_inputs = ^{app_addr, app_wdf_end};

    assign head_is_rd      = cmd_rd_q[cmd_rd_ptr];
    assign head_idx        = cmd_idx_q[cmd_rd_ptr];
    assign head_age_next   = cyc_cnt + 8'd1 - cmd_ts_q[cmd_rd_ptr];
    assign app_rd_data_end = app_rd_data_valid;
    assign dbg_state       = state;

    always_comb begin
        cmd_push    = app_en && app_rdy && (app_cmd[2:1] == 2'b00);
        cmd_illegal = app_en && app_rdy && (app_cmd[2:1] != 2'b00);
        wdf_push    = app_wdf_wren && app_wdf_rdy;
        cmd_pop     = (state == S_EXEC);
        wdf_pop     = cmd_pop && !head_is_rd;
        cmd_count_d = cmd_count + (CMD_DEPTH_LOG2+1)'(cmd_push) - (CMD_DEPTH_LOG2+1)'(cmd_pop);
        wdf_count_d = wdf_count + (WDF_DEPTH_LOG2+1)'(wdf_push) - (WDF_DEPTH_LOG2+1)'(wdf_pop);

        init_done_d = init_done || (init_cnt == 16'(INIT_CYCLES - 1));
        lfsr_d      = lfsr;
        if (init_done) lfsr_d = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
        // Counts only reach DEPTH when full, so the MSB is the full flag.
        app_rdy_d     = init_done_d && !cmd_count_d[CMD_DEPTH_LOG2]
                        && !({24'd0, lfsr_d[7:0]} < STALL_THRESH);
        app_wdf_rdy_d = init_done_d && !wdf_count_d[WDF_DEPTH_LOG2]
                        && !({24'd0, lfsr_d[15:8]} < STALL_THRESH);
    end

    // WAIT_AGE looks one cycle ahead so EXEC always retires an eligible head.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:     if (cmd_count != '0) state_d = S_WAIT_AGE;
            S_WAIT_AGE: if (({24'd0, head_age_next} >= MIN_LATENCY)
                            && (head_is_rd || wdf_count != '0 || wdf_push)) state_d = S_EXEC;
            S_EXEC:     state_d = (cmd_count_d != '0) ? S_WAIT_AGE : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            init_cnt          <= '0;
            init_done         <= 1'b0;
            cyc_cnt           <= '0;
            lfsr              <= LFSR_SEED;
            app_rdy           <= 1'b0;
            app_wdf_rdy       <= 1'b0;
            err_cmd           <= 1'b0;
            cmd_wr_ptr        <= '0;
            cmd_rd_ptr        <= '0;
            cmd_count         <= '0;
            wdf_wr_ptr        <= '0;
            wdf_rd_ptr        <= '0;
            wdf_count         <= '0;
            app_rd_data_valid <= 1'b0;
            app_rd_data       <= '0;
        end else begin
            state       <= state_d;
            if (!init_done) init_cnt <= init_cnt + 16'd1;
            init_done   <= init_done_d;
            cyc_cnt     <= cyc_cnt + 8'd1;
            lfsr        <= lfsr_d;
            app_rdy     <= app_rdy_d;
            app_wdf_rdy <= app_wdf_rdy_d;
            if (cmd_illegal) err_cmd <= 1'b1;
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
            if (wdf_push) wdf_wr_ptr <= wdf_wr_ptr + 1'b1;
            if (wdf_pop)  wdf_rd_ptr <= wdf_rd_ptr + 1'b1;
            cmd_count         <= cmd_count_d;
            wdf_count         <= wdf_count_d;
            app_rd_data_valid <= cmd_pop && head_is_rd;
            if (cmd_pop && head_is_rd) app_rd_data <= mem[head_idx];
        end
    end

    // Payload storage and memory carry no reset; contents survive a reset.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_rd_q[cmd_wr_ptr]  <= app_cmd[0];
            cmd_idx_q[cmd_wr_ptr] <= app_addr[ADDR_SHIFT +: MEM_AW];
            cmd_ts_q[cmd_wr_ptr]  <= cyc_cnt;
        end
        if (wdf_push) begin
            wdf_data_q[wdf_wr_ptr] <= app_wdf_data;
            wdf_mask_q[wdf_wr_ptr] <= app_wdf_mask;
        end
        if (wdf_pop) begin
            for (int b = 0; b < MASK_W; b++) begin
                if (!wdf_mask_q[wdf_rd_ptr][b])
                    mem[head_idx][b*8 +: 8] <= wdf_data_q[wdf_rd_ptr][b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ddr_app_model.sv
// Directed bench for ddr_app_model: order-level memory model with expected-read queue,
// per-cycle compare on the read-return channel, plus literal checks on returned data.
module tb_ddr_app_model;
  localparam int W      = 64;
  localparam int AW     = 30;
  localparam int MEM_AW = 6;
  localparam int MINLAT = 20;
  localparam int INIT   = 64;
  localparam int LIMIT  = 500;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          init_done, app_rdy, app_wdf_rdy;
  logic          app_en = 1'b0;
  logic [2:0]    app_cmd = 3'h0;
  logic [AW-1:0] app_addr = '0;
  logic          app_wdf_wren = 1'b0;
  logic          app_wdf_end = 1'b1;
  logic [W-1:0]  app_wdf_data = '0;
  logic [W/8-1:0] app_wdf_mask = '0;
  logic [W-1:0]  app_rd_data;
  logic          app_rd_data_valid, app_rd_data_end, err_cmd;
  logic [1:0]    dbg_state;

  ddr_app_model #(
    .APP_DATA_WIDTH(W), .APP_ADDR_WIDTH(AW), .ADDR_SHIFT(3), .MEM_AW(MEM_AW),
    .CMD_DEPTH_LOG2(4), .WDF_DEPTH_LOG2(4), .MIN_LATENCY(MINLAT),
    .INIT_CYCLES(INIT), .STALL_THRESH(0), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .init_done(init_done), .app_rdy(app_rdy),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr),
    .app_wdf_rdy(app_wdf_rdy), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .err_cmd(err_cmd), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0]   model_mem [1 << MEM_AW];
  bit             m_cmd_rd  [$];
  int             m_cmd_idx [$];
  int             m_cmd_acc [$];
  logic [W-1:0]   m_wdf_data [$];
  logic [W/8-1:0] m_wdf_mask [$];
  logic [W-1:0]   exp_q   [$];
  int             exp_acc [$];
  logic [W-1:0]   rd_log  [$];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Retire the model's commands in order as far as available data allows.
  task automatic model_drain();
    while (m_cmd_rd.size() > 0) begin
      if (m_cmd_rd[0]) begin
        exp_q.push_back(model_mem[m_cmd_idx[0]]);
        exp_acc.push_back(m_cmd_acc[0]);
      end else if (m_wdf_data.size() > 0) begin
        for (int b = 0; b < W/8; b++)
          if (!m_wdf_mask[0][b]) model_mem[m_cmd_idx[0]][b*8 +: 8] = m_wdf_data[0][b*8 +: 8];
        void'(m_wdf_data.pop_front());
        void'(m_wdf_mask.pop_front());
      end else begin
        break;
      end
      void'(m_cmd_rd.pop_front());
      void'(m_cmd_idx.pop_front());
      void'(m_cmd_acc.pop_front());
    end
  endtask

  task automatic model_clear();
    m_cmd_rd.delete(); m_cmd_idx.delete(); m_cmd_acc.delete();
    m_wdf_data.delete(); m_wdf_mask.delete();
    exp_q.delete(); exp_acc.delete();
  endtask

  // ---------------- compare process (negedge, away from active edge) ----------------
  always @(negedge clk) begin
    if (reset) begin
      if (!init_done) begin
        check("rdy_before_init", {63'd0, app_rdy}, '0);
        check("wdf_rdy_before_init", {63'd0, app_wdf_rdy}, '0);
      end
      if (app_rd_data_valid) begin
        check("rd_end", {63'd0, app_rd_data_end}, 64'd1);
        rd_log.push_back(app_rd_data);
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL rd_unexpected: got valid data %h required no return (cycle %0d)",
                   app_rd_data, cyc);
        end else begin
          check("rd_data", app_rd_data, exp_q.pop_front());
          check("rd_latency_ok", {63'd0, (cyc - exp_acc.pop_front()) >= MINLAT + 1}, 64'd1);
        end
      end else begin
        check("rd_end_idle", {63'd0, app_rd_data_end}, '0);
      end
      if (app_en && app_rdy && app_cmd <= 3'h1) begin
        m_cmd_rd.push_back(app_cmd == 3'h1);
        m_cmd_idx.push_back(int'(app_addr[3 +: MEM_AW]));
        m_cmd_acc.push_back(cyc);
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        m_wdf_data.push_back(app_wdf_data);
        m_wdf_mask.push_back(app_wdf_mask);
      end
      model_drain();
    end
  end

  // ---------------- driver tasks (called at posedge + 1) ----------------
  task automatic send_cmd(input logic [2:0] c, input logic [AW-1:0] a);
    int n = 0;
    app_en = 1'b1; app_cmd = c; app_addr = a;
    forever begin
      @(negedge clk);
      if (app_rdy) break;
      if (++n > LIMIT) begin
        n_checks++; n_fail++;
        $display("FAIL cmd_timeout: got app_rdy low for %0d cycles required accept", n);
        break;
      end
    end
    @(posedge clk); #1;
    app_en = 1'b0;
  endtask

  task automatic send_wdf(input logic [W-1:0] d, input logic [W/8-1:0] m);
    int n = 0;
    app_wdf_wren = 1'b1; app_wdf_data = d; app_wdf_mask = m;
    forever begin
      @(negedge clk);
      if (app_wdf_rdy) break;
      if (++n > LIMIT) begin
        n_checks++; n_fail++;
        $display("FAIL wdf_timeout: got app_wdf_rdy low for %0d cycles required accept", n);
        break;
      end
    end
    @(posedge clk); #1;
    app_wdf_wren = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 || m_cmd_rd.size() != 0 || m_wdf_data.size() != 0) begin
      @(negedge clk);
      if (++n > 2000) begin
        n_checks++; n_fail++;
        $display("FAIL drain_timeout: got %0d reads outstanding required 0", exp_q.size());
        model_clear();
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input int base, input logic [W-1:0] exp);
    if (rd_log.size() > base) check(name, rd_log[base], exp);
    else check({name, "_missing"}, 64'(rd_log.size()), 64'(base + 1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_init_done"}, {63'd0, init_done}, '0);
    check({tag, "_app_rdy"}, {63'd0, app_rdy}, '0);
    check({tag, "_wdf_rdy"}, {63'd0, app_wdf_rdy}, '0);
    check({tag, "_rd_valid"}, {63'd0, app_rd_data_valid}, '0);
    check({tag, "_rd_end"}, {63'd0, app_rd_data_end}, '0);
    check({tag, "_err_cmd"}, {63'd0, err_cmd}, '0);
    check({tag, "_rd_data"}, app_rd_data, '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base, n, accepted, first_drop;
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1; n++;
      if (init_done) break;
    end
    check("init_cycles", 64'(n), 64'(INIT));
    check("rdy_at_init", {63'd0, app_rdy}, 64'd1);

    // Full write then read of the same word.
    base = rd_log.size();
    send_cmd(3'h0, 30'h40); send_wdf({8{8'hA5}}, 8'h00);
    send_cmd(3'h1, 30'h40);
    wait_drain();
    check_log("a5_read", base, {8{8'hA5}});

    // Byte mask: only byte 0 overwritten.
    base = rd_log.size();
    send_cmd(3'h0, 30'h28); send_wdf({8{8'hFF}}, 8'h00);
    send_cmd(3'h0, 30'h28); send_wdf(64'h0, 8'hFE);
    send_cmd(3'h1, 30'h28);
    wait_drain();
    check_log("mask_read", base, 64'hFFFF_FFFF_FFFF_FF00);

    // Data ahead of commands, then reads including an aliased address.
    base = rd_log.size();
    send_wdf(64'h1, 8'h00); send_wdf(64'h2, 8'h00); send_wdf(64'h3, 8'h00);
    send_cmd(3'h0, 30'h08); send_cmd(3'h0, 30'h10); send_cmd(3'h0, 30'h18);
    send_cmd(3'h1, 30'h08); send_cmd(3'h1, 30'h10); send_cmd(3'h1, 30'h18);
    send_cmd(3'h1, 30'h208);
    wait_drain();
    check_log("early_data_0", base,     64'h1);
    check_log("early_data_1", base + 1, 64'h2);
    check_log("early_data_2", base + 2, 64'h3);
    check_log("alias_read",   base + 3, 64'h1);

    // Hold 20 back-to-back reads: FIFO fills after 16.
    base = rd_log.size();
    accepted = 0; first_drop = -1;
    for (int i = 0; i < 20; i++) begin
      app_en = 1'b1; app_cmd = 3'h1; app_addr = 30'((i % 3 + 1) << 3);
      n = 0;
      forever begin
        @(negedge clk);
        if (app_rdy) break;
        if (first_drop < 0) first_drop = accepted;
        if (++n > LIMIT) begin
          n_checks++; n_fail++;
          $display("FAIL hold_timeout: got app_rdy low required accept");
          break;
        end
      end
      @(posedge clk); #1;
      accepted++;
    end
    app_en = 1'b0;
    check("full_after", 64'(first_drop), 64'd16);
    wait_drain();
    for (int i = 0; i < 20; i++) check_log("hold_read", base + i, 64'(i % 3 + 1));

    // Illegal command: sticky flag, no read return.
    check("err_clear", {63'd0, err_cmd}, '0);
    send_cmd(3'h2, 30'h40);
    repeat (5) @(posedge clk); #1;
    check("err_set", {63'd0, err_cmd}, 64'd1);
    repeat (40) @(posedge clk); #1;
    check("err_sticky", {63'd0, err_cmd}, 64'd1);
    base = rd_log.size();
    send_cmd(3'h1, 30'h28);
    wait_drain();
    check_log("read_after_err", base, 64'hFFFF_FFFF_FFFF_FF00);

    // Asynchronous reset with reads in flight.
    send_cmd(3'h1, 30'h28); send_cmd(3'h1, 30'h40); send_cmd(3'h1, 30'h08);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    model_clear();
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (INIT + MINLAT + 10) @(posedge clk);
    #1;
    check("reinit_done", {63'd0, init_done}, 64'd1);
    check("reinit_err", {63'd0, err_cmd}, '0);
    base = rd_log.size();
    send_cmd(3'h1, 30'h28);
    wait_drain();
    check_log("mem_kept", base, 64'hFFFF_FFFF_FFFF_FF00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no end of test required finish");
    $fatal(1, "timeout");
  end
endmodule
